// File: rtl/cskip_pkg.sv
// Default geometry for the pipelined carry-skip adder and the segment-width helper.
package cskip_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int BLK_DEF   = 4;
  localparam int NSEG_DEF  = 2;

  function automatic int seg_w(input int width, input int nseg);
    return width / nseg;
  endfunction
endpackage

// File: rtl/cskip_seg.sv
// One pipeline segment: BLK-bit ripple blocks chained through skip muxes.
module cskip_seg #(
  parameter int SEG_W = 16,
  parameter int BLK   = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);
  localparam int NBLK = SEG_W / BLK;

  logic [SEG_W-1:0] p, g;
  logic [SEG_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int j = 0; j < NBLK; j++) begin
      for (int i = 0; i < BLK - 1; i++)
        c[j*BLK+i+1] = g[j*BLK+i] | (p[j*BLK+i] & c[j*BLK+i]);
      // whole block propagates: pass the block carry-in straight across
      c[(j+1)*BLK] = (&p[j*BLK +: BLK]) ? c[j*BLK]
                   : (g[(j+1)*BLK-1] | (p[(j+1)*BLK-1] & c[(j+1)*BLK-1]));
    end
  end

  assign sum     = p ^ c[SEG_W-1:0];
  assign cout    = c[SEG_W];
  assign msb_cin = c[SEG_W-1];
endmodule

// File: rtl/cskip_adder_pipe.sv
// NSEG-stage pipelined carry-skip adder/subtractor with valid/ready flow control.
// Define CSKIP_OVF_EN to add the signed-overflow output ovf.
module cskip_adder_pipe
  import cskip_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLK   = BLK_DEF,
  parameter int NSEG  = NSEG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSKIP_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int SEG_W = seg_w(WIDTH, NSEG);

  if (WIDTH % (NSEG * BLK) != 0) begin : g_chk
    $error("cskip_adder_pipe: WIDTH must be a multiple of NSEG*BLK");
  end

  logic            adv;
  logic [NSEG-1:0] vld_pipe;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[NSEG-1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= NSEG'({vld_pipe, in_valid & in_ready});

  // x carries {unprocessed a bits, resolved sum bits}; y carries only the b bits
  // still to be consumed, so the operand skew shrinks stage by stage.
  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int LO = k * SEG_W;
    localparam int RW = WIDTH - LO;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SEG_W{1'b1}}) << LO;

    logic [WIDTH-1:0] x_in, x_nxt, x_q;
    logic [RW-1:0]    y_in;
    logic [SEG_W-1:0] s;
    logic             c_in, c_nxt, c_q, msb;
    logic             unused_msb;

    if (k == 0) begin : g_src
      assign x_in = a;
      assign y_in = b ^ {WIDTH{sub}};
      assign c_in = sub | cin;
    end else begin : g_lnk
      assign x_in = g_stg[k-1].x_q;
      assign y_in = g_stg[k-1].g_y.y_q;
      assign c_in = g_stg[k-1].c_q;
    end

    cskip_seg #(.SEG_W(SEG_W), .BLK(BLK)) u_seg (
      .a      (x_in[LO +: SEG_W]),
      .b      (y_in[SEG_W-1:0]),
      .cin    (c_in),
      .sum    (s),
      .cout   (c_nxt),
      .msb_cin(msb)
    );

    assign x_nxt      = (x_in & ~MASK) | (WIDTH'(s) << LO);
    assign unused_msb = msb;

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        x_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        x_q <= x_nxt;
        c_q <= c_nxt;
      end

    if (k < NSEG - 1) begin : g_y
      logic [RW-SEG_W-1:0] y_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   y_q <= '0;
        else if (adv) y_q <= y_in[RW-1:SEG_W];
    end
  end

  assign sum  = g_stg[NSEG-1].x_q;
  assign cout = g_stg[NSEG-1].c_q;

`ifdef CSKIP_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   ovf_q <= 1'b0;
    else if (adv) ovf_q <= g_stg[NSEG-1].c_nxt ^ g_stg[NSEG-1].msb;
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Directed bench for cskip_adder_pipe with an arithmetic reference scoreboard.
module tb_cskip_adder_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
`ifdef CSKIP_OVF_EN
  logic        ovf;
`endif

  int n_chk = 0, n_fail = 0, n_out = 0, gaps = 0;
  bit prev_x = 0;

  typedef struct { logic [31:0] s; logic c; logic o; } res_t;
  res_t q[$];

  cskip_adder_pipe #(.WIDTH(32), .BLK(4), .NSEG(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CSKIP_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] x, y, input logic ci, sb);
    res_t t;
    logic [32:0] r;
    if (sb) begin
      r   = {1'b0, x} - {1'b0, y};
      t.c = (x >= y);
      t.o = (x[31] != y[31]) && (r[31] != x[31]);
    end else begin
      r   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      t.c = r[32];
      t.o = (x[31] == y[31]) && (r[31] != x[31]);
    end
    t.s = r[31:0];
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // scoreboard: every cycle a result is presented it must match the oldest accept
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_x = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("sb_no_pending", {63'd0, out_valid}, 64'd0);
        else begin
          chk("sb_sum", {32'd0, sum}, {32'd0, q[0].s});
          chk("sb_cout", {63'd0, cout}, {63'd0, q[0].c});
`ifdef CSKIP_OVF_EN
          chk("sb_ovf", {63'd0, ovf}, {63'd0, q[0].o});
`endif
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (out_valid && out_ready) prev_x = 1;
      else begin
        if (prev_x && !out_valid && q.size() > 0) gaps++;
        prev_x = 0;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [31:0] x, y, input logic ci, sb);
    bit done = 0;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) chk("send_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    bit seen = 0;
    lat = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() > 0; t++) @(posedge clk);
    #1 chk("drain_empty", q.size(), 64'd0);
  endtask

  initial begin
    int   lat, idx, base;
    bit   acc;
    res_t m;
    logic [31:0] sa [3];
    logic [31:0] sbv[3];
    logic        sc [3];

    rst_n = 0; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef CSKIP_OVF_EN
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif

    m = model(32'd5, 32'd7, 1'b0, 1'b1);
    chk("pin_sub_neg", {31'd0, m.c, m.s}, {31'd0, 1'b0, 32'hFFFFFFFE});
    m = model(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    chk("pin_wrap", {31'd0, m.c, m.s}, {31'd0, 1'b1, 32'h0});
    m = model(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    chk("pin_ovf_add", {63'd0, m.o}, 64'd1);
    m = model(32'h80000000, 32'd1, 1'b0, 1'b1);
    chk("pin_ovf_sub", {31'd0, m.o, m.s}, {31'd0, 1'b1, 32'h7FFFFFFF});

    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;

    // full skip chain: carry rides through every block of both segments
    send(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    wait_out(lat);
    chk("skip_latency", lat, 64'd2);
    chk("skip_sum", {32'd0, sum}, 64'd0);
    chk("skip_cout", {63'd0, cout}, 64'd1);

    send(32'd5, 32'd7, 1'b0, 1'b1);
    wait_out(lat);
    chk("sub57_sum", {32'd0, sum}, 64'hFFFFFFFE);
    chk("sub57_cout", {63'd0, cout}, 64'd0);

    send(32'd7, 32'd5, 1'b1, 1'b1);
    wait_out(lat);
    chk("sub75_sum", {32'd0, sum}, 64'd2);
    chk("sub75_cout", {63'd0, cout}, 64'd1);
    drain();

    // back-pressure: three operands against a stalled consumer
    sa  = '{32'd10, 32'h0000FFFF, 32'd3};
    sbv = '{32'd20, 32'd1, 32'd3};
    sc  = '{1'b0, 1'b0, 1'b1};
    base = n_out;
    @(posedge clk); #1;
    out_ready = 0; idx = 0;
    a = sa[0]; b = sbv[0]; cin = sc[0]; sub = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin a = sa[idx]; b = sbv[idx]; cin = sc[idx]; end
        else in_valid = 0;
      end
    end
    @(negedge clk);
    chk("stall_accepts", idx, 64'd2);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_held_valid", {63'd0, out_valid}, 64'd1);
    chk("stall_held_sum", {32'd0, sum}, 64'd30);
    @(posedge clk); #1;
    out_ready = 1;
    for (int t = 0; t < 10 && idx < 3; t++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; in_valid = 0; end
    end
    in_valid = 0;
    drain();
    chk("stall_results", n_out - base, 64'd3);

    // streaming: one accept and one result per cycle
    @(posedge clk); #1;
    gaps = 0; base = n_out;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain();
    chk("stream_results", n_out - base, 64'd100);
    chk("stream_gaps", gaps, 64'd0);

    // mid-flight reset discards the 1+1 operation
    send(32'd1, 32'd1, 1'b0, 1'b0);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1;
    a = 32'd2; b = 32'd3; cin = 0; sub = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_sum", {32'd0, sum}, 64'd5);
    drain();

`ifdef CSKIP_OVF_EN
    send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    wait_out(lat);
    chk("ovf_add_sum", {32'd0, sum}, 64'h80000000);
    chk("ovf_add", {63'd0, ovf}, 64'd1);
    send(32'h80000000, 32'd1, 1'b0, 1'b1);
    wait_out(lat);
    chk("ovf_sub", {63'd0, ovf}, 64'd1);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cskip_adder_pipe.md
CSKIP_ADDER_PIPE -- requirements
Module: cskip_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width.
REQ-002 SHALL have parameter BLK, default 4: carry-skip block width.
REQ-003 SHALL have parameter NSEG, default 2: pipeline segments; latency equals NSEG cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: an offered operand set is accepted this cycle.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-009 SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-010 SHALL have port sub, input, 1 bit: 1 selects a-b.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts a result.
REQ-013 SHALL have port sum, output, WIDTH bits: the result.
REQ-014 SHALL have port cout, output, 1 bit: carry-out of the MSB.

Function
REQ-015 SHALL compute {cout,sum} = a + b + cin when sub=0, and a + ~b + 1 when sub=1, modulo 2^(WIDTH+1).
REQ-016 SHALL split the operands into NSEG segments of SEG_W = WIDTH/NSEG bits; segment k (LSB first) is resolved in pipeline stage k.
REQ-017 SHALL register the segment carry between stages and delay-skew the unprocessed operand bits alongside it.
REQ-018 SHALL resolve each segment with BLK-bit ripple blocks and skip logic: a block's carry-out equals its carry-in when every bit propagates (a^b).
REQ-019 SHALL drive one global advance signal, adv = !out_valid | out_ready; all stage registers load only when adv=1.
REQ-020 SHALL drive in_ready = adv; a transfer occurs when in_valid & in_ready.
REQ-021 SHALL give each stage a valid bit; stage 0 loads in_valid & in_ready on adv.
REQ-022 SHALL present a result accepted on cycle t at out_valid on cycle t+NSEG when no stall occurs.
REQ-023 SHALL sustain one result per cycle when out_ready is held at 1.
REQ-024 SHALL hold sum, cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL allow a simultaneous accept and emit in the same cycle when the pipeline is full and out_ready=1.
REQ-026 SHALL let bubbles (in_valid=0) propagate as valid=0 without altering data registers beyond the adv rule.
REQ-027 SHALL fail elaboration when WIDTH mod (NSEG*BLK) is non-zero.

Reset
REQ-028 SHALL, while rst_n=0, clear all valid bits, carries and data registers to 0; out_valid=0, sum=0, cout=0, in_ready=1.
REQ-029 SHALL discard all in-flight operations on a mid-operation reset; no result emerges after release.
REQ-030 SHALL accept a new operand on the first clk edge after rst_n deasserts.

Configuration
REQ-031 SHALL, when the macro CSKIP_OVF_EN is defined, add output port ovf (1 bit): signed overflow computed from the MSB carry-in and carry-out, pipelined and held with sum; ovf resets to 0.
REQ-032 SHALL, when CSKIP_OVF_EN is undefined, have no ovf port and no overflow logic.

Structure
REQ-033 SHALL define package cskip_pkg containing the default WIDTH, BLK and NSEG constants and a function returning SEG_W.
REQ-034 SHALL implement one combinational sub-module, cskip_seg (SEG_W, BLK), with ports a, b, cin, sum, cout and msb_cin; cskip_adder_pipe SHALL instantiate it NSEG times.

Verification (WIDTH=32, BLK=4, NSEG=2)
REQ-035 SHALL cover: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> sum=0x00000000, cout=1, out_valid exactly 2 cycles after acceptance (full skip chain).
REQ-036 SHALL cover: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-037 SHALL cover: 3 back-to-back operand sets with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, the first result is held unchanged, and all 3 results emerge in order once out_ready=1.
REQ-038 SHALL cover: 100 random operand sets with out_ready=1 and in_valid=1 -> one result per cycle, all matching the reference model.
REQ-039 SHALL cover: rst_n pulsed low 1 cycle after accepting a=1, b=1 -> out_valid stays 0 and no stale result appears after release.
REQ-040 SHALL cover, with CSKIP_OVF_EN defined: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1; a=0x80000000, b=1, sub=1 -> ovf=1.
